// File: rtl/mmd_ctrl.sv
// Multi-modulus divider controller: buffers MASH divide ratios in a small FIFO and
// counts VCO cycles per division period, producing a pulse and a ~50% divided clock.
module mmd_ctrl #(
    parameter int unsigned P_DATA_WIDTH = 8,
    parameter int unsigned P_MIN_DIV    = 4,
    parameter int unsigned P_FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_en,
    input  logic [P_DATA_WIDTH-1:0]       i_div,
    input  logic                          i_div_valid,
    output logic                          o_div_ready,
    input  logic                          i_clr_flags,
    output logic                          o_pulse,
    output logic                          o_div_out,
    output logic                          o_busy,
    output logic                          o_clamp,
    output logic                          o_underrun,
    output logic [$clog2(P_FIFO_DEPTH):0] o_level
);
    localparam int unsigned AW = $clog2(P_FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [P_DATA_WIDTH-1:0] MIN_DIV = P_DATA_WIDTH'(P_MIN_DIV);
    localparam logic [LW-1:0]           DEPTH   = LW'(P_FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_COUNT} state_t;

    state_t                  state_q, state_d;
    logic [P_DATA_WIDTH-1:0] cnt_q, cnt_d;
    logic [P_DATA_WIDTH-1:0] last_n_q, last_n_d;
    logic [P_DATA_WIDTH-1:0] mem [P_FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]           level_q, level_d;
    logic                    wr, pop, fifo_load, clamp_d, underrun_set, underrun_d;
    logic                    pulse_d, div_out_d, busy_d, ready_d;
    logic [P_DATA_WIDTH-1:0] head, n_eff;

    assign wr    = i_div_valid && o_div_ready;
    assign head  = mem[rd_ptr_q];
    assign n_eff = (head < MIN_DIV) ? MIN_DIV : head;

    // Next-state, counter reload and registered-output decode
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_n_d     = last_n_q;
        fifo_load    = 1'b0;
        pop          = 1'b0;
        clamp_d      = 1'b0;
        underrun_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_en && (level_q != '0)) fifo_load = 1'b1;
            end
            S_COUNT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - P_DATA_WIDTH'(1);
                end else if (!i_en) begin
                    state_d = S_IDLE;
                end else if (level_q != '0) begin
                    fifo_load = 1'b1;
                end else begin
                    // Starved: repeat the previous ratio rather than stall the loop
                    cnt_d        = last_n_q - P_DATA_WIDTH'(1);
                    underrun_set = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (fifo_load) begin
            pop      = 1'b1;
            state_d  = S_COUNT;
            cnt_d    = n_eff - P_DATA_WIDTH'(1);
            last_n_d = n_eff;
            clamp_d  = (head < MIN_DIV);
        end
        level_d    = level_q + LW'(wr) - LW'(pop);
        ready_d    = (level_d != DEPTH);
        busy_d     = (state_d == S_COUNT);
        pulse_d    = busy_d && (cnt_d == '0);
        div_out_d  = busy_d && (cnt_d >= (last_n_d >> 1));
        underrun_d = underrun_set ? 1'b1 : (i_clr_flags ? 1'b0 : o_underrun);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            last_n_q    <= MIN_DIV;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            o_div_ready <= 1'b1;
            o_pulse     <= 1'b0;
            o_div_out   <= 1'b0;
            o_busy      <= 1'b0;
            o_clamp     <= 1'b0;
            o_underrun  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_n_q    <= last_n_d;
            level_q     <= level_d;
            o_div_ready <= ready_d;
            o_pulse     <= pulse_d;
            o_div_out   <= div_out_d;
            o_busy      <= busy_d;
            o_clamp     <= clamp_d;
            o_underrun  <= underrun_d;
            if (wr)  wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    // Ratio storage needs no reset; occupancy is tracked by level_q
    always_ff @(posedge i_clk) begin
        if (wr) mem[wr_ptr_q] <= i_div;
    end

    assign o_level = level_q;

endmodule

// File: doc/mmd_ctrl.md
MMD_CTRL -- requirements
Module: mmd_ctrl

Interface
REQ-001 SHALL provide parameter P_DATA_WIDTH, default 8, width of the divide ratio.
REQ-002 SHALL provide parameter P_MIN_DIV, default 4, smallest legal divide ratio.
REQ-003 SHALL provide parameter P_FIFO_DEPTH, default 4, ratio buffer depth (power of 2, >= 2).
REQ-004 SHALL have i_clk, input, 1, divider (VCO-rate) clock; all state on rising edge.
REQ-005 SHALL have i_rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have i_en, input, 1, division enable.
REQ-007 SHALL have i_div, input, P_DATA_WIDTH, unsigned divide ratio N from the MASH output.
REQ-008 SHALL have i_div_valid, input, 1, i_div is valid.
REQ-009 SHALL have o_div_ready, output, 1, buffer can accept a ratio.
REQ-010 SHALL have i_clr_flags, input, 1, synchronous clear of sticky flags.
REQ-011 SHALL have o_pulse, output, 1, one-cycle pulse on the last cycle of each division period.
REQ-012 SHALL have o_div_out, output, 1, divided clock.
REQ-013 SHALL have o_busy, output, 1, high while in COUNT.
REQ-014 SHALL have o_clamp, output, 1, one-cycle pulse when a loaded ratio was clamped.
REQ-015 SHALL have o_underrun, output, 1, sticky flag: a period started with an empty buffer.
REQ-016 SHALL have o_level, output, clog2(P_FIFO_DEPTH)+1, buffer occupancy.

Function
REQ-017 SHALL write i_div into the FIFO on every edge with i_div_valid=1 and o_div_ready=1.
REQ-018 SHALL drive o_div_ready = ~full, from registered state only; no write when full, even if a pop occurs that cycle.
REQ-019 SHALL implement states IDLE and COUNT with a down-counter cnt.
REQ-020 IDLE -> COUNT when i_en=1 and FIFO non-empty: pop, N_eff = max(N, P_MIN_DIV), cnt <= N_eff-1, latch N_eff as last_n.
REQ-021 In COUNT, cnt SHALL decrement by 1 per cycle; the period SHALL last exactly N_eff cycles (cnt N_eff-1 .. 0).
REQ-022 o_pulse SHALL equal (state==COUNT && cnt==0).
REQ-023 At cnt==0 with i_en=1 and FIFO non-empty, SHALL pop and reload in the same edge with no gap cycle.
REQ-024 At cnt==0 with i_en=1 and FIFO empty, SHALL reload with last_n and set o_underrun; a write in that same cycle is used on the following period.
REQ-025 At cnt==0 with i_en=0, SHALL go to IDLE without popping; deasserting i_en mid-period SHALL NOT truncate the current period.
REQ-026 o_clamp SHALL pulse one cycle, the cycle after any load where N < P_MIN_DIV, including N=0.
REQ-027 o_div_out SHALL be registered: 1 for the first N_eff-(N_eff>>1) cycles of each period and 0 for the remaining N_eff>>1; 0 in IDLE.
REQ-028 o_level SHALL equal writes minus pops, update on the edge of either, and be unchanged on a simultaneous write and pop.
REQ-029 Pointers SHALL wrap modulo P_FIFO_DEPTH; FIFO data SHALL be preserved in order across wrap.
REQ-030 i_clr_flags=1 SHALL clear o_underrun; a set event in the same cycle SHALL take priority.

Reset
REQ-031 While i_rst_n=0: state=IDLE, cnt=0, last_n=P_MIN_DIV, FIFO empty, o_level=0, o_pulse=0, o_div_out=0, o_busy=0, o_clamp=0, o_underrun=0, o_div_ready=1.
REQ-032 Reset asserted mid-period SHALL abort immediately and discard buffered ratios; after release SHALL wait in IDLE for a new ratio.

Verification
REQ-033 Write 10,10,10; i_en=1 -> o_pulse every 10 cycles; o_div_out 5 high / 5 low; no underrun.
REQ-034 Write 7 then 8 back-to-back -> periods of 7 then 8 cycles, no gap; o_div_out high 4 then 4 cycles.
REQ-035 Write 2 -> period 4 cycles, o_clamp one pulse; write 0 -> same.
REQ-036 Write single 6 and keep i_en=1 -> second period is 6 cycles, o_underrun=1 until i_clr_flags.
REQ-037 Fill 4 entries with i_en=0 -> o_div_ready=0, o_level=4, extra valid ignored; enable -> ratios consumed in order, ready=1 after first pop.
REQ-038 Assert i_rst_n=0 at cnt=3 of a 12-cycle period -> all outputs at reset values within the reset cycle, o_level=0.
